mont_mult_r2: RTL and testbench

Radix-2, bit-serial Montgomery multiplier. It computes z = x·y·2^-K mod M for the NIST P-192 modulus. It is the multiply engine driven by the modular-exponentiation controller, which issues a one-cycle start, waits for done, then captures z. One operand bit is processed per clock, and a single conditional final subtraction guarantees z < M.

---
 rtl/mont_mult_r2_pkg.sv | 17 +
 rtl/mont_mult_r2_if.sv | 13 +
 rtl/mont_mult_r2_step.sv | 22 ++
 rtl/mont_mult_r2.sv | 93 +++++++++
 tb/tb_mont_mult_r2.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mont_mult_r2_pkg.sv
// Shared constants and state encoding for the radix-2 P-192 Montgomery multiplier.
package mont_pkg;

  localparam int unsigned K    = 192;
  localparam int unsigned LOGK = 8;

  localparam logic [K-1:0] M_P192   = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
  localparam logic [K-1:0] R_MOD_M  = 192'h000000000000000000000000000000010000000000000001;
  localparam logic [K-1:0] R2_MOD_M = 192'h000000000000000100000000000000020000000000000001;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINAL
  } state_e;

endpackage

// File: rtl/mont_mult_r2_if.sv
// Operand/result handshake between the exponentiation controller and the multiplier.
interface mont_mult_r2_if;

  logic [mont_pkg::K-1:0] x;
  logic [mont_pkg::K-1:0] y;
  logic                   start;
  logic [mont_pkg::K-1:0] z;
  logic                   done;

  modport master (output x, output y, output start, input z, input done);
  modport slave  (input x, input y, input start, output z, output done);

endinterface

// File: rtl/mont_mult_r2_step.sv
// One radix-2 Montgomery iteration: p' = (p + x_bit*y [+ M]) / 2.
module mont_step
  import mont_pkg::*;
(
  input  logic [K+1:0] p_i,
  input  logic         xbit_i,
  input  logic [K-1:0] ys_i,
  input  logic [K-1:0] m_i,
  output logic [K+1:0] p_o
);

  logic [K+1:0] a;
  logic [K+1:0] a_odd;

  // p < 2M and y, M < M keep the sum below 4M, which fits in K+2 bits.
  always_comb begin
    a     = p_i + (xbit_i ? {2'b00, ys_i} : '0);
    a_odd = a[0] ? (a + {2'b00, m_i}) : a;
    p_o   = a_odd >> 1;
  end

endmodule

// File: rtl/mont_mult_r2.sv
// Bit-serial Montgomery multiplier z = x*y*2^-K mod M; FSM, counter, operand copies and result register.
module mont_mult_r2
  import mont_pkg::*;
#(
  parameter logic [K-1:0] M = M_P192
) (
  input  logic            clk,
  input  logic            reset,
  mont_mult_r2_if.slave   bus
);

  state_e          state_q, state_d;
  logic [K-1:0]    xs_q, xs_d;
  logic [K-1:0]    ys_q, ys_d;
  logic [K+1:0]    p_q, p_d;
  logic [LOGK-1:0] i_q, i_d;
  logic [K-1:0]    z_q, z_d;
  logic            done_q, done_d;

  logic [K+1:0]    p_step;
  logic            p_ge_m;
  logic [K-1:0]    p_red;

  mont_step u_step (
    .p_i    (p_q),
    .xbit_i (xs_q[0]),
    .ys_i   (ys_q),
    .m_i    (M),
    .p_o    (p_step)
  );

  // Final reduction only needs K+1 bits since p < 2M after the last iteration.
  assign p_ge_m = (p_q[K:0] >= {1'b0, M});
  assign p_red  = K'(p_q[K:0] - {1'b0, M});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      p_q     <= '0;
      i_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      p_q     <= p_d;
      i_q     <= i_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    p_d     = p_q;
    i_d     = i_q;
    z_d     = z_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          xs_d    = bus.x;
          ys_d    = bus.y;
          p_d     = '0;
          i_d     = '0;
          done_d  = 1'b0;
          state_d = ITER;
        end
      end
      ITER: begin
        p_d  = p_step;
        xs_d = xs_q >> 1;
        i_d  = i_q + LOGK'(1);
        if (i_q == LOGK'(K - 1)) state_d = FINAL;
      end
      FINAL: begin
        z_d     = p_ge_m ? p_red : p_q[K-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.z    = z_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mont_mult_r2.sv
// Directed vector bench for mont_mult_r2 with hand-computed Montgomery products.
module tb_mont_mult_r2;
  import mont_pkg::*;

  typedef struct {
    logic [K-1:0] x;
    logic [K-1:0] y;
    logic [K-1:0] z;
    string        name;
  } vec_t;

  localparam int unsigned LAT    = K + 1;
  localparam int unsigned BUDGET = 400;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  mont_mult_r2_if bus ();

  mont_mult_r2 #(.M(M_P192)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [K-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one start pulse; returns just after the sampling edge with x/y scrambled.
  task automatic start_op(input logic [K-1:0] x, input logic [K-1:0] y);
    @(negedge clk);
    bus.x     = x;
    bus.y     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = rnd();
    bus.y     = rnd();
  endtask

  // Counts edges until done; optionally pokes a start (with new operands) mid-operation.
  task automatic wait_done(input int poke, output int n, output logic zstable);
    logic [K-1:0] zref;
    zref    = bus.z;
    zstable = 1'b1;
    n       = 0;
    while (n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
      if (bus.z !== zref) zstable = 1'b0;
      if (poke != 0 && n == poke) begin
        bus.start = 1'b1;
        bus.x     = rnd();
        bus.y     = rnd();
      end
      if (poke != 0 && n == poke + 1) bus.start = 1'b0;
    end
  endtask

  initial begin
    vec_t         vecs[9];
    int           n;
    logic         zs;
    logic [K-1:0] m1;

    m1 = M_P192 - 1;
    vecs[0] = '{R_MOD_M,  1,        192'h1,                                              "r_times_1"};
    vecs[1] = '{R2_MOD_M, 1,        R_MOD_M,                                             "r2_times_1"};
    vecs[2] = '{m1,       R2_MOD_M, 192'hfffffffffffffffffffffffffffffffdfffffffffffffffe, "m1_times_r2"};
    vecs[3] = '{0,        m1,       0,                                                   "x_zero"};
    vecs[4] = '{1,        0,        0,                                                   "y_zero"};
    vecs[5] = '{m1,       R_MOD_M,  m1,                                                  "m1_times_r"};
    vecs[6] = '{R2_MOD_M, 5,        192'h000000000000000000000000000000050000000000000005, "r2_times_5"};
    vecs[7] = '{R2_MOD_M, R_MOD_M,  R2_MOD_M,                                            "r2_times_r"};
    vecs[8] = '{R_MOD_M,  12345,    192'd12345,                                          "r_times_12345"};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", K'(bus.done), 1);
    chk("reset_z", bus.z, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int unsigned v = 0; v < 9; v++) begin
      start_op(vecs[v].x, vecs[v].y);
      chk({vecs[v].name, "_done_low"}, K'(bus.done), 0);
      wait_done(0, n, zs);
      chk({vecs[v].name, "_latency"}, K'(n), K'(LAT));
      chk({vecs[v].name, "_z"}, bus.z, vecs[v].z);
      chk({vecs[v].name, "_z_held"}, K'(zs), 1);
    end

    // start pulse mid-operation with new operands must not disturb the result
    start_op(R2_MOD_M, 7);
    wait_done(50, n, zs);
    chk("ignored_start_latency", K'(n), K'(LAT));
    chk("ignored_start_z", bus.z, 192'h000000000000000000000000000000070000000000000007);
    @(posedge clk);
    #1;
    chk("ignored_start_no_restart", K'(bus.done), 1);

    // asynchronous reset mid-operation
    start_op(R2_MOD_M, R2_MOD_M);
    repeat (99) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midop_reset_done", K'(bus.done), 1);
    chk("midop_reset_z", bus.z, 0);
    @(negedge clk);
    reset = 1'b0;
    start_op(R_MOD_M, 5);
    wait_done(0, n, zs);
    chk("post_reset_latency", K'(n), K'(LAT));
    chk("post_reset_z", bus.z, 5);

    // start held high across two back-to-back operations
    @(negedge clk);
    bus.x     = R2_MOD_M;
    bus.y     = 1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("held_first_done_low", K'(bus.done), 0);
    wait_done(0, n, zs);
    chk("held_first_latency", K'(n), K'(LAT));
    chk("held_first_z", bus.z, R_MOD_M);
    bus.x = R_MOD_M;
    bus.y = 7;
    @(posedge clk);
    #1;
    chk("held_second_started", K'(bus.done), 0);
    chk("held_z_stable", bus.z, R_MOD_M);
    bus.start = 1'b0;
    wait_done(0, n, zs);
    chk("held_second_latency", K'(n), K'(LAT));
    chk("held_second_z", bus.z, 7);
    chk("held_second_z_held", K'(zs), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
